// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and datapath typedefs
package cpu_pkg;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [4:0]  REG_SP   = 5'd29;
    localparam logic [4:0]  REG_RA   = 5'd31;
    localparam logic [31:0] SP_RESET = 32'd227;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

endpackage

// File: rtl/reg_bank_if.sv
// rtl/reg_bank_if.sv - register file write/read port bundle
interface reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2,
        input  read_data1, read_data2
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2,
        output read_data1, read_data2
    );
endinterface

// File: rtl/reg_bank_rdport.sv
// rtl/reg_bank_rdport.sv - one registered read port with write bypass and r0 override
module reg_bank_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] read_data
);
    logic              hit;
    logic [DATA_W-1:0] next_data;

    // r0 wins over the bypass so a discarded write to r0 never leaks out
    always_comb begin
        hit       = reg_write && (write_reg != '0) && (write_reg == read_reg);
        next_data = stored;
        if (read_reg == '0) begin
            next_data = '0;
        end else if (hit) begin
            next_data = write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= '0;
        end else begin
            read_data <= next_data;
        end
    end
endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - 32-entry register file, one write port, two registered read ports
module reg_bank
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    reg_bank_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    // stack pointer comes out of reset pointing at its initial top
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == int'(REG_SP)) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (bus.reg_write && (bus.write_reg != '0)) begin
            regs[bus.write_reg] <= bus.write_data;
        end
    end

    assign stored1 = regs[bus.read_reg1];
    assign stored2 = regs[bus.read_reg2];

    reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .reg_write  (bus.reg_write),
        .write_reg  (bus.write_reg),
        .write_data (bus.write_data),
        .read_reg   (bus.read_reg1),
        .stored     (stored1),
        .read_data  (bus.read_data1)
    );

    reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .reg_write  (bus.reg_write),
        .write_reg  (bus.write_reg),
        .write_data (bus.write_data),
        .read_reg   (bus.read_reg2),
        .stored     (stored2),
        .read_data  (bus.read_data2)
    );
endmodule
